// File: rtl/memcore_stream_reader_if.sv
// Command, memory-port and output-stream signals of memcore_stream_reader.
// The out_last signal exists only when MEMCORE_READER_LAST_EN is defined.
interface memcore_stream_reader_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 6,
   parameter int LEN_WIDTH     = 7
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [ADDRESS_WIDTH-1:0] cmd_base;
   logic [LEN_WIDTH-1:0]     cmd_len;

   logic [ADDRESS_WIDTH-1:0] mem_address;
   logic                     mem_ce;
   logic                     mem_we;
   logic [DATA_WIDTH-1:0]    mem_q;

   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_WIDTH-1:0]    out_data;
   logic                     done;
`ifdef MEMCORE_READER_LAST_EN
   logic                     out_last;
`endif

   modport master (
      input  cmd_valid, cmd_base, cmd_len, mem_q, out_ready,
      output cmd_ready, mem_address, mem_ce, mem_we, out_valid, out_data, done
`ifdef MEMCORE_READER_LAST_EN
      , output out_last
`endif
   );

   modport slave (
      output cmd_valid, cmd_base, cmd_len, mem_q, out_ready,
      input  cmd_ready, mem_address, mem_ce, mem_we, out_valid, out_data, done
`ifdef MEMCORE_READER_LAST_EN
      , input out_last
`endif
   );
endinterface

// File: rtl/memcore_stream_reader.sv
// Turns a (base, length) command into sequential BRAM reads and a valid/ready stream.
// Define MEMCORE_READER_LAST_EN to add out_last on the final beat of each command.
module memcore_stream_reader #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 6,
   parameter int ADDRESS_RANGE = 64,
   parameter int LEN_WIDTH     = 7
) (
   input logic                     clk,
   input logic                     reset,
   memcore_stream_reader_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

`ifdef MEMCORE_READER_LAST_EN
   localparam int EW = DATA_WIDTH + 1;
`else
   localparam int EW = DATA_WIDTH;
`endif

   state_e                   state_q, state_d;
   logic                     cmd_ready_q, cmd_ready_d;
   logic                     done_q, done_d;
   logic [ADDRESS_WIDTH-1:0] next_addr_q, next_addr_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [LEN_WIDTH-1:0]     reads_left_q, reads_left_d;
   logic [LEN_WIDTH-1:0]     beats_left_q, beats_left_d;
   logic                     rd_pending_q, rd_pending_d;
   logic [EW-1:0]            fifo_q [2];
   logic [EW-1:0]            fifo_d [2];
   logic                     wr_ptr_q, wr_ptr_d;
   logic                     rd_ptr_q, rd_ptr_d;
   logic [1:0]               count_q, count_d;

   logic [1:0]               in_use;
   logic                     pop;
   logic                     issue;
   logic [EW-1:0]            entry_in;

`ifdef MEMCORE_READER_LAST_EN
   logic                     rd_last_q, rd_last_d;
   assign entry_in     = {rd_last_q, bus.mem_q};
   assign bus.out_last = (count_q != 2'd0) && fifo_q[rd_ptr_q][DATA_WIDTH];
`else
   assign entry_in     = bus.mem_q;
`endif

   // Buffered words plus the read in flight never exceed the two buffer slots.
   assign pop    = (count_q != 2'd0) && bus.out_ready;
   assign in_use = count_q + {1'b0, rd_pending_q};
   assign issue  = (state_q == RUN) && ((in_use - {1'b0, pop}) < 2'd2);

   assign bus.mem_ce      = issue;
   assign bus.mem_address = issue ? next_addr_q : mem_addr_q;
   assign bus.mem_we      = 1'b0;
   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.out_valid   = (count_q != 2'd0);
   assign bus.out_data    = fifo_q[rd_ptr_q][DATA_WIDTH-1:0];
   assign bus.done        = done_q;

   always_comb begin
      // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
      state_d      = state_q;
      cmd_ready_d  = cmd_ready_q;
      done_d       = 1'b0;
      next_addr_d  = next_addr_q;
      mem_addr_d   = mem_addr_q;
      reads_left_d = reads_left_q;
      beats_left_d = beats_left_q;
      rd_pending_d = issue;
      fifo_d       = fifo_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q + {1'b0, rd_pending_q} - {1'b0, pop};
`ifdef MEMCORE_READER_LAST_EN
      rd_last_d    = issue && (reads_left_q == LEN_WIDTH'(1));
`endif

      if (rd_pending_q) begin
         fifo_d[wr_ptr_q] = entry_in;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d     = ~rd_ptr_q;
         beats_left_d = beats_left_q - LEN_WIDTH'(1);
      end
      if (issue) begin
         mem_addr_d   = next_addr_q;
         next_addr_d  = (next_addr_q == ADDRESS_WIDTH'(ADDRESS_RANGE - 1))
                        ? '0 : next_addr_q + ADDRESS_WIDTH'(1);
         reads_left_d = reads_left_q - LEN_WIDTH'(1);
      end

      case (state_q)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               next_addr_d  = bus.cmd_base;
               reads_left_d = bus.cmd_len;
               beats_left_d = bus.cmd_len;
               if (bus.cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = RUN;
                  cmd_ready_d = 1'b0;
               end
            end
         end
         RUN: begin
            if (issue && (reads_left_q == LEN_WIDTH'(1))) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop && (beats_left_q == LEN_WIDTH'(1))) begin
               state_d     = IDLE;
               cmd_ready_d = 1'b1;
               done_d      = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cmd_ready_q  <= 1'b1;
         done_q       <= 1'b0;
         next_addr_q  <= '0;
         mem_addr_q   <= '0;
         reads_left_q <= '0;
         beats_left_q <= '0;
         rd_pending_q <= 1'b0;
         // NOTE: the two buffer slots are reset so out_data reads zero out of reset.
         fifo_q[0]    <= '0;
         fifo_q[1]    <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
`ifdef MEMCORE_READER_LAST_EN
         rd_last_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         done_q       <= done_d;
         next_addr_q  <= next_addr_d;
         mem_addr_q   <= mem_addr_d;
         reads_left_q <= reads_left_d;
         beats_left_q <= beats_left_d;
         rd_pending_q <= rd_pending_d;
         fifo_q       <= fifo_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
`ifdef MEMCORE_READER_LAST_EN
         rd_last_q    <= rd_last_d;
`endif
      end
   end
endmodule

// File: tb/tb_memcore_stream_reader.sv
// Self-checking bench for memcore_stream_reader: a one-cycle-latency memory model,
// a port monitor, and per-scenario tasks compared against a queue-based reference model.
module tb_memcore_stream_reader;
   localparam int DW = 32;
   localparam int AW = 6;
   localparam int AR = 64;
   localparam int LW = 7;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   ready_mode;
   int   clear_tok;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   memcore_stream_reader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

   memcore_stream_reader #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ADDRESS_RANGE(AR), .LEN_WIDTH(LW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   logic [DW-1:0] mem [AR];

   always @(posedge clk) begin
      if (reset)           bus.mem_q <= '0;
      else if (bus.mem_ce) bus.mem_q <= mem[bus.mem_address];
   end

   // Consumer ready: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
   initial begin
      int ph;
      ph = 0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       bus.out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
            2:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b1;
         endcase
         ph++;
      end
   end

   // Port monitor: records events per cycle and counts protocol violations.
   logic [DW-1:0] beat_q [$];
   int            beat_cyc [$];
   bit            beat_last [$];
   int            ce_cyc [$];
   logic [AW-1:0] ce_addr [$];
   int            done_cyc [$];
   int            valid_cnt, notready_cnt, stall_err, credit_err, hold_err, we_err;

   initial begin
      int            seen_tok, issued, popped;
      bit            prev_stall, pop, prev_last;
      logic [DW-1:0] prev_data;
      logic [AW-1:0] last_addr;
      seen_tok = 0; issued = 0; popped = 0; prev_stall = 0; prev_last = 0;
      prev_data = '0; last_addr = '0;
      valid_cnt = 0; notready_cnt = 0; stall_err = 0; credit_err = 0; hold_err = 0; we_err = 0;
      forever begin
         @(negedge clk);
         if (seen_tok != clear_tok) begin
            seen_tok = clear_tok;
            beat_q.delete(); beat_cyc.delete(); beat_last.delete();
            ce_cyc.delete(); ce_addr.delete(); done_cyc.delete();
            valid_cnt = 0; notready_cnt = 0; stall_err = 0; credit_err = 0; hold_err = 0;
            issued = 0; popped = 0;
         end
         if (bus.mem_we !== 1'b0) we_err++;
         if (reset) begin
            issued = 0; popped = 0; prev_stall = 0; last_addr = '0;
         end else begin
            pop = bus.out_valid && bus.out_ready;
            if ((issued - popped) - int'(pop) + int'(bus.mem_ce) > 2) credit_err++;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stall_err++;
`ifdef MEMCORE_READER_LAST_EN
            if (prev_stall && bus.out_last !== prev_last) stall_err++;
            prev_last = bus.out_last;
`endif
            if (!bus.mem_ce && bus.mem_address !== last_addr) hold_err++;
            if (bus.mem_ce) begin
               ce_cyc.push_back(cyc);
               ce_addr.push_back(bus.mem_address);
               last_addr = bus.mem_address;
               issued++;
            end
            if (pop) begin
               beat_q.push_back(bus.out_data);
               beat_cyc.push_back(cyc);
`ifdef MEMCORE_READER_LAST_EN
               beat_last.push_back(bus.out_last);
`else
               beat_last.push_back(1'b0);
`endif
               popped++;
            end
            if (bus.done)       done_cyc.push_back(cyc);
            if (bus.out_valid)  valid_cnt++;
            if (!bus.cmd_ready) notready_cnt++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
         end
      end
   end

   // Reference model: the stream is memory read at base, base+1, ... modulo ADDRESS_RANGE.
   logic [DW-1:0] exp_q [$];
   int            exp_addr [$];

   task automatic model_append(input int base, input int len);
      for (int i = 0; i < len; i++) begin
         exp_addr.push_back((base + i) % AR);
         exp_q.push_back(mem[(base + i) % AR]);
      end
   endtask

   task automatic start_scenario();
      clear_tok++;
      exp_q.delete();
      exp_addr.delete();
   endtask

   task automatic send_cmd(input int base, input int len, input bit hold, output int hs);
      hs = -1;
      @(posedge clk);
      #1;
      bus.cmd_base  = AW'(base);
      bus.cmd_len   = LW'(len);
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            hs = cyc;
            break;
         end
      end
      n_cmp++;
      if (hs < 0) begin
         $display("FAIL cmd_handshake: cmd_ready never seen, required within 400 cycles");
         n_err++;
      end
      @(posedge clk);
      #1;
      if (!hold || hs < 0) bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget);
      int k;
      k = 0;
      while (done_cyc.size() < n && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      n_cmp++;
      if (done_cyc.size() < n) begin
         $display("FAIL done_timeout: got %0d done pulses, required %0d within %0d cycles",
                  done_cyc.size(), n, budget);
         n_err++;
      end
      repeat (4) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp += 7;
      if (bus.cmd_ready !== 1'b1) begin $display("FAIL reset_cmd_ready: got %b, required 1", bus.cmd_ready); n_err++; end
      if (bus.mem_ce !== 1'b0) begin $display("FAIL reset_mem_ce: got %b, required 0", bus.mem_ce); n_err++; end
      if (bus.mem_address !== '0) begin $display("FAIL reset_mem_address: got %0d, required 0", bus.mem_address); n_err++; end
      if (bus.mem_we !== 1'b0) begin $display("FAIL reset_mem_we: got %b, required 0", bus.mem_we); n_err++; end
      if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); n_err++; end
      if (bus.out_data !== '0) begin $display("FAIL reset_out_data: got %h, required 0", bus.out_data); n_err++; end
      if (bus.done !== 1'b0) begin $display("FAIL reset_done: got %b, required 0", bus.done); n_err++; end
`ifdef MEMCORE_READER_LAST_EN
      n_cmp++;
      if (bus.out_last !== 1'b0) begin $display("FAIL reset_out_last: got %b, required 0", bus.out_last); n_err++; end
`endif
      #1;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int n;
      ready_mode = 0;
      for (int i = 0; i < 4; i++) mem[i] = 32'h100 + DW'(i);
      start_scenario();
      send_cmd(0, 4, 1'b0, n);
      wait_done(1, 100);
      n_cmp += 3;
      if (ce_cyc.size() != 4) begin $display("FAIL basic_ce_count: got %0d, required 4", ce_cyc.size()); n_err++; end
      if (beat_q.size() != 4) begin $display("FAIL basic_beat_count: got %0d, required 4", beat_q.size()); n_err++; end
      if (done_cyc.size() != 1 || done_cyc[0] != n + 7) begin
         $display("FAIL basic_done_cycle: got %0d pulses first at %0d, required 1 at %0d",
                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, n + 7);
         n_err++;
      end
      for (int i = 0; i < ce_cyc.size() && i < 4; i++) begin
         n_cmp++;
         if (ce_cyc[i] != n + 1 + i || ce_addr[i] !== AW'(i)) begin
            $display("FAIL basic_read[%0d]: got cycle %0d addr %0d, required cycle %0d addr %0d",
                     i, ce_cyc[i], ce_addr[i], n + 1 + i, i);
            n_err++;
         end
      end
      for (int i = 0; i < beat_q.size() && i < 4; i++) begin
         n_cmp++;
         if (beat_q[i] !== 32'h100 + DW'(i) || beat_cyc[i] != n + 3 + i) begin
            $display("FAIL basic_beat[%0d]: got %h at cycle %0d, required %h at cycle %0d",
                     i, beat_q[i], beat_cyc[i], 32'h100 + i, n + 3 + i);
            n_err++;
         end
`ifdef MEMCORE_READER_LAST_EN
         n_cmp++;
         if (beat_last[i] != (i == 3)) begin
            $display("FAIL basic_last[%0d]: got %b, required %b", i, beat_last[i], i == 3);
            n_err++;
         end
`endif
      end
   endtask

   task automatic test_wrap();
      int n;
      ready_mode = 0;
      start_scenario();
      model_append(62, 4);
      send_cmd(62, 4, 1'b0, n);
      wait_done(1, 100);
      n_cmp++;
      if (ce_addr.size() != 4 || beat_q.size() != 4) begin
         $display("FAIL wrap_counts: got %0d reads %0d beats, required 4 and 4", ce_addr.size(), beat_q.size());
         n_err++;
      end
      for (int i = 0; i < 4 && i < ce_addr.size() && i < beat_q.size(); i++) begin
         n_cmp++;
         if (int'(ce_addr[i]) != exp_addr[i] || beat_q[i] !== exp_q[i]) begin
            $display("FAIL wrap_word[%0d]: got addr %0d data %h, required addr %0d data %h",
                     i, ce_addr[i], beat_q[i], exp_addr[i], exp_q[i]);
            n_err++;
         end
      end
   endtask

   task automatic test_backpressure();
      int n, base;
      ready_mode = 1;
      base = $urandom_range(0, AR - 1);
      start_scenario();
      model_append(base, 8);
      send_cmd(base, 8, 1'b0, n);
      wait_done(1, 200);
      n_cmp += 4;
      if (beat_q.size() != 8) begin $display("FAIL bp_beat_count: got %0d, required 8", beat_q.size()); n_err++; end
      if (stall_err != 0) begin $display("FAIL bp_stall_hold: got %0d unstable stall cycles, required 0", stall_err); n_err++; end
      if (credit_err != 0) begin $display("FAIL bp_credit: got %0d cycles over 2 outstanding, required 0", credit_err); n_err++; end
      if (hold_err != 0) begin $display("FAIL bp_addr_hold: got %0d address changes without mem_ce, required 0", hold_err); n_err++; end
      for (int i = 0; i < beat_q.size() && i < 8; i++) begin
         n_cmp++;
         if (beat_q[i] !== exp_q[i]) begin
            $display("FAIL bp_beat[%0d]: got %h, required %h", i, beat_q[i], exp_q[i]);
            n_err++;
         end
      end
      ready_mode = 0;
   endtask

   task automatic test_len_zero();
      int n;
      ready_mode = 0;
      start_scenario();
      send_cmd($urandom_range(0, AR - 1), 0, 1'b0, n);
      wait_done(1, 20);
      n_cmp += 4;
      if (ce_cyc.size() != 0) begin $display("FAIL len0_mem_ce: got %0d reads, required 0", ce_cyc.size()); n_err++; end
      if (valid_cnt != 0) begin $display("FAIL len0_out_valid: got %0d valid cycles, required 0", valid_cnt); n_err++; end
      if (notready_cnt != 0) begin $display("FAIL len0_cmd_ready: got %0d busy cycles, required 0", notready_cnt); n_err++; end
      if (done_cyc.size() != 1 || done_cyc[0] != n + 1) begin
         $display("FAIL len0_done: got %0d pulses first at %0d, required 1 at %0d",
                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, n + 1);
         n_err++;
      end
   endtask

   task automatic test_reset_mid();
      int n, k;
      ready_mode = 0;
      start_scenario();
      send_cmd($urandom_range(0, AR - 1), 6, 1'b0, n);
      k = 0;
      while (beat_q.size() < 2 && k < 50) begin
         @(negedge clk);
         #1;
         k++;
      end
      n_cmp++;
      if (beat_q.size() != 2) begin $display("FAIL rstmid_pre_beats: got %0d, required 2", beat_q.size()); n_err++; end
      reset = 1'b1;
      @(negedge clk);
      #1;
      n_cmp += 4;
      if (bus.out_valid !== 1'b0) begin $display("FAIL rstmid_out_valid: got %b, required 0", bus.out_valid); n_err++; end
      if (bus.mem_ce !== 1'b0) begin $display("FAIL rstmid_mem_ce: got %b, required 0", bus.mem_ce); n_err++; end
      if (bus.cmd_ready !== 1'b1) begin $display("FAIL rstmid_cmd_ready: got %b, required 1", bus.cmd_ready); n_err++; end
      if (bus.done !== 1'b0) begin $display("FAIL rstmid_done_now: got %b, required 0", bus.done); n_err++; end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      n_cmp++;
      if (done_cyc.size() != 0) begin $display("FAIL rstmid_no_done: got %0d pulses, required 0", done_cyc.size()); n_err++; end
      start_scenario();
      model_append(10, 2);
      send_cmd(10, 2, 1'b0, n);
      wait_done(1, 100);
      n_cmp++;
      if (beat_q.size() != 2) begin $display("FAIL rstmid_after_count: got %0d beats, required 2", beat_q.size()); n_err++; end
      for (int i = 0; i < beat_q.size() && i < 2; i++) begin
         n_cmp++;
         if (beat_q[i] !== exp_q[i]) begin
            $display("FAIL rstmid_after_beat[%0d]: got %h, required %h", i, beat_q[i], exp_q[i]);
            n_err++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int n1, n2, b1, b2, l1, l2;
      ready_mode = 0;
      b1 = $urandom_range(0, AR - 1); l1 = $urandom_range(3, 8);
      b2 = $urandom_range(0, AR - 1); l2 = $urandom_range(1, 5);
      start_scenario();
      model_append(b1, l1);
      model_append(b2, l2);
      send_cmd(b1, l1, 1'b1, n1);
      send_cmd(b2, l2, 1'b0, n2);
      wait_done(2, 200);
      n_cmp += 4;
      if (done_cyc.size() != 2) begin $display("FAIL b2b_done_count: got %0d, required 2", done_cyc.size()); n_err++; end
      if (done_cyc.size() < 1 || n2 != done_cyc[0] || n2 != n1 + 3 + l1) begin
         $display("FAIL b2b_accept_cycle: got %0d, required %0d (done of first)", n2, n1 + 3 + l1);
         n_err++;
      end
      if (beat_cyc.size() <= l1 || beat_cyc[l1] != n2 + 3) begin
         $display("FAIL b2b_first_beat: got cycle %0d, required %0d",
                  (beat_cyc.size() > l1) ? beat_cyc[l1] : -1, n2 + 3);
         n_err++;
      end
      if (beat_q.size() != l1 + l2) begin $display("FAIL b2b_beat_count: got %0d, required %0d", beat_q.size(), l1 + l2); n_err++; end
      for (int i = 0; i < beat_q.size() && i < l1 + l2; i++) begin
         n_cmp++;
         if (beat_q[i] !== exp_q[i]) begin
            $display("FAIL b2b_beat[%0d]: got %h, required %h", i, beat_q[i], exp_q[i]);
            n_err++;
         end
      end
   endtask

   task automatic test_random();
      int n, base, len;
      ready_mode = 2;
      for (int t = 0; t < 6; t++) begin
         base = $urandom_range(0, AR - 1);
         len  = $urandom_range(1, AR);
         start_scenario();
         model_append(base, len);
         send_cmd(base, len, 1'b0, n);
         wait_done(1, 1000);
         n_cmp += 4;
         if (beat_q.size() != len) begin $display("FAIL rand%0d_beat_count: got %0d, required %0d", t, beat_q.size(), len); n_err++; end
         if (done_cyc.size() != 1) begin $display("FAIL rand%0d_done_count: got %0d, required 1", t, done_cyc.size()); n_err++; end
         if (stall_err + hold_err != 0) begin $display("FAIL rand%0d_stability: got %0d stall and %0d addr errors, required 0", t, stall_err, hold_err); n_err++; end
         if (credit_err != 0) begin $display("FAIL rand%0d_credit: got %0d, required 0", t, credit_err); n_err++; end
         for (int i = 0; i < beat_q.size() && i < len; i++) begin
            n_cmp++;
            if (beat_q[i] !== exp_q[i] || int'(ce_addr[i]) != exp_addr[i]) begin
               $display("FAIL rand%0d_beat[%0d]: got addr %0d data %h, required addr %0d data %h",
                        t, i, ce_addr[i], beat_q[i], exp_addr[i], exp_q[i]);
               n_err++;
            end
`ifdef MEMCORE_READER_LAST_EN
            n_cmp++;
            if (beat_last[i] != (i == len - 1)) begin
               $display("FAIL rand%0d_last[%0d]: got %b, required %b", t, i, beat_last[i], i == len - 1);
               n_err++;
            end
`endif
         end
      end
      n_cmp++;
      if (we_err != 0) begin $display("FAIL mem_we_constant: got %0d cycles with mem_we high, required 0", we_err); n_err++; end
      ready_mode = 0;
   endtask

   initial begin
      reset         = 1'b1;
      ready_mode    = 0;
      clear_tok     = 0;
      bus.cmd_valid = 1'b0;
      bus.cmd_base  = '0;
      bus.cmd_len   = '0;
      for (int i = 0; i < AR; i++) mem[i] = $urandom();
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_len_zero();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion earlier");
      $fatal(1, "watchdog");
   end
endmodule
